// File: rtl/axi_ar_router_if.sv
// Bundle of the AXI read-path signals around axi_ar_router.
// The slave modport is the router's view (it is the slave of the upstream
// master); the master modport is the opposite view, used by whatever drives
// the upstream master and models the downstream slaves.
interface axi_ar_router_if #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4
);
  logic [ADDR_W-1:0]            M_ARADDR;
  logic [ID_W-1:0]              M_ARID;
  logic [7:0]                   M_ARLEN;
  logic                         M_ARVALID;
  logic                         M_ARREADY;
  logic [DATA_W-1:0]            M_RDATA;
  logic [ID_W-1:0]              M_RID;
  logic [1:0]                   M_RRESP;
  logic                         M_RLAST;
  logic                         M_RVALID;
  logic                         M_RREADY;
  logic [ADDR_W-1:0]            S_ARADDR;
  logic [ID_W-1:0]              S_ARID;
  logic [7:0]                   S_ARLEN;
  logic [NUM_SLAVES-1:0]        S_ARVALID;
  logic [NUM_SLAVES-1:0]        S_ARREADY;
  logic [NUM_SLAVES*DATA_W-1:0] S_RDATA;
  logic [NUM_SLAVES*ID_W-1:0]   S_RID;
  logic [NUM_SLAVES*2-1:0]      S_RRESP;
  logic [NUM_SLAVES-1:0]        S_RLAST;
  logic [NUM_SLAVES-1:0]        S_RVALID;
  logic [NUM_SLAVES-1:0]        S_RREADY;
  logic [15:0]                  decerr_cnt;

  modport slave (
    input  M_ARADDR, M_ARID, M_ARLEN, M_ARVALID, M_RREADY,
           S_ARREADY, S_RDATA, S_RID, S_RRESP, S_RLAST, S_RVALID,
    output M_ARREADY, M_RDATA, M_RID, M_RRESP, M_RLAST, M_RVALID,
           S_ARADDR, S_ARID, S_ARLEN, S_ARVALID, S_RREADY, decerr_cnt
  );

  modport master (
    output M_ARADDR, M_ARID, M_ARLEN, M_ARVALID, M_RREADY,
           S_ARREADY, S_RDATA, S_RID, S_RRESP, S_RLAST, S_RVALID,
    input  M_ARREADY, M_RDATA, M_RID, M_RRESP, M_RLAST, M_RVALID,
           S_ARADDR, S_ARID, S_ARLEN, S_ARVALID, S_RREADY, decerr_cnt
  );
endinterface

// File: rtl/axi_ar_router.sv
// AXI read-path router: one master port fanned out to NUM_SLAVES slaves plus
// an internal default slave answering unmapped addresses with DECERR bursts.
// Outstanding bursts are only allowed to a single target at a time, which
// keeps R beats in order without an ID table.
// Optional feature macro: AXI_AR_ROUTER_DECERR_CNT_EN (saturating 16-bit
// count of bursts sent to the default slave on decerr_cnt; tied to 0 when
// the macro is undefined).
module axi_ar_router #(
  parameter int NUM_SLAVES      = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int ID_W            = 4,
  parameter int DEC_MSB         = 31,
  parameter int DEC_LSB         = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic              ACLK,
  input logic              ARESETn,
  axi_ar_router_if.slave   bus
);
  localparam int DEC_W = DEC_MSB - DEC_LSB + 1;
  localparam int TGT_W = 4;
  localparam int CNT_W = 4;
  localparam logic [TGT_W-1:0] DEF     = TGT_W'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {D_IDLE, D_BURST} dstate_t;

  dstate_t          state, state_nx;
  logic [CNT_W-1:0] out_cnt;
  logic [TGT_W-1:0] cur_tgt;
  logic [7:0]       beats;
  logic [ID_W-1:0]  d_id;

  logic [DEC_W-1:0] idx;
  logic [TGT_W-1:0] target;
  logic             accept;
  logic             ar_hs;
  logic             def_hs;
  logic             r_done;
  logic             d_beat;

  // Address decode: in-range field selects a slave, anything else the default slave
  always_comb begin
    idx    = bus.M_ARADDR[DEC_MSB:DEC_LSB];
    target = (idx < DEC_W'(NUM_SLAVES)) ? TGT_W'(idx) : DEF;
  end

  // AR channel: zero-latency pass-through to the decoded target when allowed
  always_comb begin
    accept        = ARESETn && bus.M_ARVALID
                    && (out_cnt == '0 || target == cur_tgt)
                    && (out_cnt < MAX_OUT);
    bus.S_ARADDR  = {ADDR_W{ARESETn}} & bus.M_ARADDR;
    bus.S_ARID    = {ID_W{ARESETn}} & bus.M_ARID;
    bus.S_ARLEN   = {8{ARESETn}} & bus.M_ARLEN;
    bus.S_ARVALID = '0;
    bus.M_ARREADY = 1'b0;
    if (accept) begin
      if (target == DEF) begin
        bus.M_ARREADY = (state == D_IDLE);
      end else begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (target == TGT_W'(i)) begin
            bus.S_ARVALID[i] = 1'b1;
            bus.M_ARREADY    = bus.S_ARREADY[i];
          end
        end
      end
    end
  end

  // R channel: return beats only from the target that owns the outstanding bursts
  always_comb begin
    bus.M_RVALID = 1'b0;
    bus.M_RDATA  = '0;
    bus.M_RID    = '0;
    bus.M_RRESP  = 2'b00;
    bus.M_RLAST  = 1'b0;
    bus.S_RREADY = '0;
    if (out_cnt != '0) begin
      if (cur_tgt == DEF) begin
        bus.M_RVALID = (state == D_BURST);
        bus.M_RRESP  = 2'b11;
        bus.M_RID    = d_id;
        bus.M_RLAST  = (beats == 8'd0);
      end else begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (cur_tgt == TGT_W'(i)) begin
            bus.M_RVALID    = bus.S_RVALID[i];
            bus.M_RDATA     = bus.S_RDATA[i*DATA_W +: DATA_W];
            bus.M_RID       = bus.S_RID[i*ID_W +: ID_W];
            bus.M_RRESP     = bus.S_RRESP[i*2 +: 2];
            bus.M_RLAST     = bus.S_RLAST[i];
            bus.S_RREADY[i] = bus.M_RREADY;
          end
        end
      end
    end
  end

  // Handshake events shared by the counters and the default-slave FSM
  always_comb begin
    ar_hs  = bus.M_ARVALID && bus.M_ARREADY;
    def_hs = ar_hs && (target == DEF);
    r_done = bus.M_RVALID && bus.M_RREADY && bus.M_RLAST;
    d_beat = (state == D_BURST) && bus.M_RREADY;
  end

  // Outstanding-burst count and owning target
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      out_cnt <= '0;
      cur_tgt <= '0;
    end else begin
      if (ar_hs && !r_done)      out_cnt <= out_cnt + 1'b1;
      else if (!ar_hs && r_done) out_cnt <= out_cnt - 1'b1;
      if (ar_hs) cur_tgt <= target;
    end
  end

  // Default-slave state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= D_IDLE;
    else          state <= state_nx;
  end

  // Default-slave next state: one DECERR burst at a time
  always_comb begin
    state_nx = state;
    case (state)
      D_IDLE:  if (def_hs) state_nx = D_BURST;
      D_BURST: if (d_beat && beats == 8'd0) state_nx = D_IDLE;
      default: state_nx = D_IDLE;
    endcase
  end

  // Default-slave burst bookkeeping: latched ID and remaining beats
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      d_id  <= '0;
      beats <= '0;
    end else if (state == D_IDLE && def_hs) begin
      d_id  <= bus.M_ARID;
      beats <= bus.M_ARLEN;
    end else if (d_beat && beats != 8'd0) begin
      beats <= beats - 8'd1;
    end
  end

`ifdef AXI_AR_ROUTER_DECERR_CNT_EN
  logic [15:0] dcnt;

  // Saturating count of bursts routed to the default slave
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                          dcnt <= '0;
    else if (def_hs && dcnt != 16'hFFFF)   dcnt <= dcnt + 16'd1;
  end

  assign bus.decerr_cnt = dcnt;
`else
  assign bus.decerr_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_axi_ar_router.sv
// Directed bench for axi_ar_router with default parameters (2 slaves,
// decode on ARADDR[31:16], 4 outstanding bursts).
module tb_axi_ar_router;
  logic ACLK;
  logic ARESETn;
  int   total = 0;
  int   bad   = 0;

  axi_ar_router_if #(.NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

  axi_ar_router #(
    .NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32), .ID_W(4),
    .DEC_MSB(31), .DEC_LSB(16), .MAX_OUTSTANDING(4)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .bus(bus)
  );

`ifdef AXI_AR_ROUTER_DECERR_CNT_EN
  localparam logic [15:0] ONE_DEC = 16'd1;
`else
  localparam logic [15:0] ONE_DEC = 16'd0;
`endif

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  s_ardy;
    logic [1:0]  exp_sav;
    logic        exp_ardy;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         output logic [1:0] sav, output logic ok);
    bus.M_ARADDR  = addr;
    bus.M_ARID    = id;
    bus.M_ARLEN   = len;
    bus.M_ARVALID = 1'b1;
    ok  = 1'b0;
    sav = 2'b00;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.M_ARREADY) begin
        ok  = 1'b1;
        sav = bus.S_ARVALID;
      end
      tick();
    end
    bus.M_ARVALID = 1'b0;
  endtask

  task automatic ar_expect(input string name, input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [1:0] exp_sav);
    logic [1:0] sav;
    logic       ok;
    ar_send(addr, id, len, sav, ok);
    chk({name, "_accepted"}, ok, 1'b1);
    chk({name, "_s_arvalid"}, sav, exp_sav);
  endtask

  task automatic s_beat(input int s, input logic [31:0] data, input logic [3:0] id, input logic last);
    bus.S_RVALID              = '0;
    bus.S_RLAST               = '0;
    bus.S_RRESP               = '0;
    bus.S_RVALID[s]           = 1'b1;
    bus.S_RLAST[s]            = last;
    bus.S_RDATA[s*32 +: 32]   = data;
    bus.S_RID[s*4 +: 4]       = id;
  endtask

  initial begin
    vecs[0] = '{32'h0000_1234, 2'b11, 2'b01, 1'b1};
    vecs[1] = '{32'h0000_1234, 2'b10, 2'b01, 1'b0};
    vecs[2] = '{32'h0001_0040, 2'b10, 2'b10, 1'b1};
    vecs[3] = '{32'h0001_FFFC, 2'b01, 2'b10, 1'b0};
    vecs[4] = '{32'h0002_0000, 2'b00, 2'b00, 1'b1};
    vecs[5] = '{32'hFFFF_0000, 2'b11, 2'b00, 1'b1};
    vecs[6] = '{32'h0005_0000, 2'b11, 2'b00, 1'b1};

    // reset: outputs held at zero even with live inputs
    ARESETn       = 1'b0;
    bus.M_ARADDR  = 32'h0001_0000;
    bus.M_ARID    = 4'h3;
    bus.M_ARLEN   = 8'd0;
    bus.M_ARVALID = 1'b1;
    bus.M_RREADY  = 1'b1;
    bus.S_ARREADY = 2'b11;
    bus.S_RDATA   = 64'h1111_2222_3333_4444;
    bus.S_RID     = 8'h55;
    bus.S_RRESP   = 4'h0;
    bus.S_RLAST   = 2'b11;
    bus.S_RVALID  = 2'b11;
    #12;
    chk("rst_m_arready", bus.M_ARREADY, 1'b0);
    chk("rst_s_arvalid", bus.S_ARVALID, 2'b00);
    chk("rst_s_araddr", bus.S_ARADDR, 32'h0);
    chk("rst_m_rvalid", bus.M_RVALID, 1'b0);
    chk("rst_s_rready", bus.S_RREADY, 2'b00);
    chk("rst_decerr_cnt", bus.decerr_cnt, 16'h0);
    bus.M_ARVALID = 1'b0;
    bus.S_RVALID  = 2'b00;
    bus.S_RLAST   = 2'b00;
    bus.S_ARREADY = 2'b00;
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
    chk("idle_out_cnt", dut.out_cnt, 4'd0);

    // combinational decode table, ARVALID dropped before each edge
    for (int v = 0; v < 7; v++) begin
      bus.M_ARADDR  = vecs[v].addr;
      bus.S_ARREADY = vecs[v].s_ardy;
      bus.M_ARVALID = 1'b1;
      #1;
      chk($sformatf("vec%0d_s_arvalid", v), bus.S_ARVALID, vecs[v].exp_sav);
      chk($sformatf("vec%0d_m_arready", v), bus.M_ARREADY, vecs[v].exp_ardy);
      chk($sformatf("vec%0d_s_araddr", v), bus.S_ARADDR, vecs[v].addr);
      bus.M_ARVALID = 1'b0;
      tick();
    end
    chk("vec_out_cnt", dut.out_cnt, 4'd0);

    // slave1 burst of 4 beats
    bus.S_ARREADY = 2'b11;
    ar_expect("a_ar", 32'h0001_0040, 4'h5, 8'd3, 2'b10);
    chk("a_out_cnt1", dut.out_cnt, 4'd1);
    for (int k = 0; k < 4; k++) begin
      s_beat(1, 32'hA000_0000 + k, 4'h5, k == 3);
      #1;
      chk($sformatf("a_rvalid%0d", k), bus.M_RVALID, 1'b1);
      chk($sformatf("a_rdata%0d", k), bus.M_RDATA, 32'hA000_0000 + k);
      chk($sformatf("a_rid%0d", k), bus.M_RID, 4'h5);
      chk($sformatf("a_rlast%0d", k), bus.M_RLAST, k == 3);
      chk($sformatf("a_s_rready%0d", k), bus.S_RREADY, 2'b10);
      tick();
    end
    bus.S_RVALID = 2'b00;
    #1;
    chk("a_out_cnt0", dut.out_cnt, 4'd0);

    // DECERR burst of 3 beats, with one stalled cycle
    ar_expect("b_ar", 32'h0005_0000, 4'h7, 8'd2, 2'b00);
    bus.M_RREADY = 1'b0;
    tick();
    chk("b_hold_rvalid", bus.M_RVALID, 1'b1);
    chk("b_hold_rlast", bus.M_RLAST, 1'b0);
    chk("b_hold_s_rready", bus.S_RREADY, 2'b00);
    bus.M_RREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("b_rvalid%0d", k), bus.M_RVALID, 1'b1);
      chk($sformatf("b_rresp%0d", k), bus.M_RRESP, 2'b11);
      chk($sformatf("b_rid%0d", k), bus.M_RID, 4'h7);
      chk($sformatf("b_rdata%0d", k), bus.M_RDATA, 32'h0);
      chk($sformatf("b_rlast%0d", k), bus.M_RLAST, k == 2);
      tick();
    end
    #1;
    chk("b_rvalid_end", bus.M_RVALID, 1'b0);
    chk("b_out_cnt0", dut.out_cnt, 4'd0);
    chk("b_decerr_cnt", bus.decerr_cnt, ONE_DEC);

    // outstanding limit: four single-beat bursts to slave0, fifth stalls
    bus.S_ARREADY = 2'b01;
    for (int i = 0; i < 4; i++)
      ar_expect($sformatf("c_ar%0d", i), 32'h0000_0100 + 32'(i * 16), 4'(i), 8'd0, 2'b01);
    chk("c_out_cnt4", dut.out_cnt, 4'd4);
    bus.M_ARADDR  = 32'h0000_0200;
    bus.M_ARID    = 4'h9;
    bus.M_ARLEN   = 8'd0;
    bus.M_ARVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("c_stall_ardy%0d", i), bus.M_ARREADY, 1'b0);
      chk($sformatf("c_stall_sav%0d", i), bus.S_ARVALID, 2'b00);
      tick();
    end
    s_beat(0, 32'hC0, 4'h0, 1'b1);
    #1;
    chk("c_done_rlast", bus.M_RLAST, 1'b1);
    chk("c_done_ardy", bus.M_ARREADY, 1'b0);
    tick();
    bus.S_RVALID = 2'b00;
    #1;
    chk("c_out_cnt3", dut.out_cnt, 4'd3);
    chk("c_resume_ardy", bus.M_ARREADY, 1'b1);
    tick();
    bus.M_ARVALID = 1'b0;
    chk("c_out_cnt4b", dut.out_cnt, 4'd4);
    for (int i = 0; i < 4; i++) begin
      s_beat(0, 32'hC1 + i, 4'(i + 1), 1'b1);
      tick();
    end
    bus.S_RVALID = 2'b00;
    #1;
    chk("c_out_cnt0", dut.out_cnt, 4'd0);

    // target switch blocked until the slave0 burst completes
    bus.S_ARREADY = 2'b11;
    ar_expect("d_ar0", 32'h0000_0000, 4'h1, 8'd0, 2'b01);
    bus.M_ARADDR  = 32'h0001_0000;
    bus.M_ARID    = 4'h2;
    bus.M_ARLEN   = 8'd0;
    bus.M_ARVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("d_block_ardy%0d", i), bus.M_ARREADY, 1'b0);
      chk($sformatf("d_block_sav%0d", i), bus.S_ARVALID, 2'b00);
      tick();
    end
    s_beat(0, 32'h55, 4'h1, 1'b1);
    #1;
    chk("d_last_ardy", bus.M_ARREADY, 1'b0);
    tick();
    bus.S_RVALID = 2'b00;
    #1;
    chk("d_switch_ardy", bus.M_ARREADY, 1'b1);
    chk("d_switch_sav", bus.S_ARVALID, 2'b10);
    tick();
    bus.M_ARVALID = 1'b0;
    chk("d_cur_tgt", dut.cur_tgt, 4'd1);
    chk("d_out_cnt1", dut.out_cnt, 4'd1);

    // final RLAST and same-target AR in the same cycle
    bus.M_ARADDR  = 32'h0001_0080;
    bus.M_ARID    = 4'h3;
    bus.M_ARLEN   = 8'd0;
    bus.M_ARVALID = 1'b1;
    s_beat(1, 32'h77, 4'h2, 1'b1);
    #1;
    chk("e_ardy", bus.M_ARREADY, 1'b1);
    chk("e_rlast", bus.M_RLAST, 1'b1);
    chk("e_rid", bus.M_RID, 4'h2);
    chk("e_rdata", bus.M_RDATA, 32'h77);
    tick();
    bus.M_ARVALID = 1'b0;
    bus.S_RVALID  = 2'b00;
    #1;
    chk("e_out_cnt1", dut.out_cnt, 4'd1);
    chk("e_cur_tgt", dut.cur_tgt, 4'd1);
    chk("e_no_extra", bus.M_RVALID, 1'b0);
    s_beat(1, 32'h88, 4'h3, 1'b1);
    #1;
    chk("e_beat2_rvalid", bus.M_RVALID, 1'b1);
    chk("e_beat2_rid", bus.M_RID, 4'h3);
    tick();
    bus.S_RVALID = 2'b00;
    #1;
    chk("e_out_cnt0", dut.out_cnt, 4'd0);
    chk("e_idle_rvalid", bus.M_RVALID, 1'b0);

    // asynchronous reset in the middle of a DECERR burst
    ar_expect("f_ar", 32'h0005_0000, 4'h9, 8'd3, 2'b00);
    tick();
    chk("f_beat2_rvalid", bus.M_RVALID, 1'b1);
    chk("f_beat2_rlast", bus.M_RLAST, 1'b0);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("f_rst_rvalid", bus.M_RVALID, 1'b0);
    chk("f_rst_out_cnt", dut.out_cnt, 4'd0);
    chk("f_rst_fsm_idle", dut.state == dut.D_IDLE, 1'b1);
    chk("f_rst_decerr", bus.decerr_cnt, 16'h0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
    chk("f_post_rvalid", bus.M_RVALID, 1'b0);
    ar_expect("f_ar2", 32'h0000_0040, 4'h4, 8'd0, 2'b01);
    chk("f_out_cnt1", dut.out_cnt, 4'd1);
    s_beat(0, 32'h99, 4'h4, 1'b1);
    #1;
    chk("f_rdata", bus.M_RDATA, 32'h99);
    tick();
    bus.S_RVALID = 2'b00;
    #1;
    chk("f_out_cnt0", dut.out_cnt, 4'd0);

    // ARLEN=0 DECERR: single beat with RLAST
    ar_expect("g_ar", 32'h0003_0000, 4'h6, 8'd0, 2'b00);
    #1;
    chk("g_rvalid", bus.M_RVALID, 1'b1);
    chk("g_rlast", bus.M_RLAST, 1'b1);
    chk("g_rid", bus.M_RID, 4'h6);
    tick();
    chk("g_rvalid_end", bus.M_RVALID, 1'b0);
    chk("g_out_cnt0", dut.out_cnt, 4'd0);
    chk("g_decerr_cnt", bus.decerr_cnt, ONE_DEC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
